// File: rtl/glitch_sweep_sched.sv
// Sweeps glitch delay/length across console reset cycles and watches the debug code for success.
// Define GLITCH_SWEEP_REPORT_EN to add the REPORT state with a result_valid/result_ready handshake.
module glitch_sweep_sched #(
  parameter logic [15:0] RESET_CYCLES = 16'h0010,
  parameter logic [15:0] DELAY_MIN    = 16'h0001,
  parameter logic [15:0] DELAY_MAX    = 16'h0300,
  parameter logic [15:0] LEN_MIN      = 16'h0100,
  parameter logic [15:0] LEN_MAX      = 16'h0180,
  parameter logic [23:0] WIN_CYCLES   = 24'hF0000,
  parameter logic [7:0]  SUCCESS_A    = 8'h88,
  parameter logic [7:0]  SUCCESS_B    = 8'h25
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  dbg,
  output logic        reset_out_n,
  output logic        glitch_out,
  output logic        busy,
  output logic        found,
  output logic [15:0] cur_delay,
  output logic [15:0] cur_len,
  output logic [23:0] attempts,
  output logic        result_valid,
  output logic [7:0]  result_code,
  input  logic        result_ready
);

  typedef enum logic [2:0] {
    IDLE, RESET, DELAY, GLITCH, WATCH, REPORT, HOLD, DONE
  } state_t;

  state_t      state;
  logic [23:0] cnt;
  logic [24:0] cnt_nx;
  logic        dbg_hit;
  logic        watch_end;
  logic        sweep_end;
  logic        finish_go;
  logic        finish_hit;
  logic [15:0] next_delay;
  logic [15:0] next_len;

  assign cnt_nx    = {1'b0, cnt} + 25'd1;
  assign dbg_hit   = (dbg == SUCCESS_A) || (dbg == SUCCESS_B);
  assign watch_end = dbg_hit || (cnt_nx >= {1'b0, WIN_CYCLES});
  assign sweep_end = (cur_delay == DELAY_MAX) && (cur_len == LEN_MAX);

`ifdef GLITCH_SWEEP_REPORT_EN
  assign finish_go  = (state == REPORT) && result_valid && result_ready;
  assign finish_hit = (result_code == SUCCESS_A) || (result_code == SUCCESS_B);
`else
  logic unused_ready;
  assign unused_ready = result_ready;
  assign finish_go    = (state == WATCH) && watch_end;
  assign finish_hit   = dbg_hit;
`endif

  // Delay is the inner loop of the sweep; length only steps when delay wraps.
  always_comb begin
    next_delay = DELAY_MIN;
    next_len   = cur_len + 16'd1;
    if (cur_delay < DELAY_MAX) begin
      next_delay = cur_delay + 16'd1;
      next_len   = cur_len;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      cnt          <= '0;
      reset_out_n  <= 1'b1;
      glitch_out   <= 1'b0;
      busy         <= 1'b0;
      found        <= 1'b0;
      result_valid <= 1'b0;
      result_code  <= '0;
      attempts     <= '0;
      cur_delay    <= DELAY_MIN;
      cur_len      <= LEN_MIN;
    end else if (abort) begin
      state        <= IDLE;
      cnt          <= '0;
      reset_out_n  <= 1'b1;
      glitch_out   <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD, DONE: begin
          if (start) begin
            state       <= RESET;
            cnt         <= '0;
            reset_out_n <= 1'b0;
            busy        <= 1'b1;
            found       <= 1'b0;
            attempts    <= '0;
            cur_delay   <= DELAY_MIN;
            cur_len     <= LEN_MIN;
          end
        end
        RESET: begin
          if (cnt_nx >= {9'd0, RESET_CYCLES}) begin
            cnt         <= '0;
            reset_out_n <= 1'b1;
            if (cur_delay == 16'd0) begin
              state      <= GLITCH;
              glitch_out <= 1'b1;
            end else begin
              state <= DELAY;
            end
          end else begin
            cnt <= cnt_nx[23:0];
          end
        end
        DELAY: begin
          if (cnt_nx >= {9'd0, cur_delay}) begin
            cnt        <= '0;
            state      <= GLITCH;
            glitch_out <= 1'b1;
          end else begin
            cnt <= cnt_nx[23:0];
          end
        end
        GLITCH: begin
          if (cnt_nx >= {9'd0, cur_len}) begin
            cnt        <= '0;
            state      <= WATCH;
            glitch_out <= 1'b0;
          end else begin
            cnt <= cnt_nx[23:0];
          end
        end
        WATCH: begin
          if (watch_end) begin
            cnt         <= '0;
            result_code <= dbg;
            if (attempts != 24'hFFFFFF) attempts <= attempts + 24'd1;
            if (dbg_hit) found <= 1'b1;
`ifdef GLITCH_SWEEP_REPORT_EN
            state        <= REPORT;
            result_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt_nx[23:0];
          end
        end
        default: state <= IDLE;
      endcase

      // Shared end-of-attempt decision: latch success, finish the sweep, or step parameters.
      if (finish_go) begin
        result_valid <= 1'b0;
        if (finish_hit) begin
          state <= HOLD;
          busy  <= 1'b0;
          found <= 1'b1;
        end else if (sweep_end) begin
          state <= DONE;
          busy  <= 1'b0;
        end else begin
          state       <= RESET;
          cnt         <= '0;
          reset_out_n <= 1'b0;
          cur_delay   <= next_delay;
          cur_len     <= next_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_glitch_sweep_sched.sv
// Self-checking bench for glitch_sweep_sched: randomized dbg noise against a phase-level timeline model.
module tb_glitch_sweep_sched;

  localparam logic [15:0] RC   = 16'd4;
  localparam logic [15:0] DMIN = 16'd2;
  localparam logic [15:0] DMAX = 16'd3;
  localparam logic [15:0] LMIN = 16'd1;
  localparam logic [15:0] LMAX = 16'd2;
  localparam logic [23:0] WIN  = 24'd8;
`ifdef GLITCH_SWEEP_REPORT_EN
  localparam bit REPORT_EN = 1'b1;
`else
  localparam bit REPORT_EN = 1'b0;
`endif

  // Expected {reset_out_n, glitch_out, busy, result_valid} per phase.
  localparam logic [3:0] V_RESET  = 4'b0010;
  localparam logic [3:0] V_DELAY  = 4'b1010;
  localparam logic [3:0] V_GLITCH = 4'b1110;
  localparam logic [3:0] V_WATCH  = 4'b1010;
  localparam logic [3:0] V_REPORT = 4'b1011;
  localparam logic [3:0] V_IDLE   = 4'b1000;

  logic        CLK = 1'b0;
  logic        RST_N, start, abort, result_ready;
  logic [7:0]  dbg;
  logic        reset_out_n, glitch_out, busy, found, result_valid;
  logic [15:0] cur_delay, cur_len;
  logic [23:0] attempts;
  logic [7:0]  result_code;

  int checks   = 0;
  int failures = 0;

  typedef struct { int d; int l; } attempt_t;
  attempt_t plan[$];

  glitch_sweep_sched #(
    .RESET_CYCLES(RC), .DELAY_MIN(DMIN), .DELAY_MAX(DMAX),
    .LEN_MIN(LMIN), .LEN_MAX(LMAX), .WIN_CYCLES(WIN),
    .SUCCESS_A(8'h88), .SUCCESS_B(8'h25)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .dbg(dbg),
    .reset_out_n(reset_out_n), .glitch_out(glitch_out), .busy(busy), .found(found),
    .cur_delay(cur_delay), .cur_len(cur_len), .attempts(attempts),
    .result_valid(result_valid), .result_code(result_code), .result_ready(result_ready)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [3:0] exp_vec, input logic [7:0] dbg_val);
    checkOutput(tag, {28'd0, reset_out_n, glitch_out, busy, result_valid}, {28'd0, exp_vec});
    dbg = dbg_val;
    @(posedge CLK); #1;
  endtask

  // Success codes appear often so that ignoring them outside WATCH is exercised.
  function automatic logic [7:0] noisyCode();
    case ($urandom_range(3))
      0:       return 8'h88;
      1:       return 8'h25;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] quietCode();
    logic [7:0] c;
    c = 8'($urandom);
    if (c == 8'h88 || c == 8'h25) c = 8'h00;
    return c;
  endfunction

  task automatic startSweep();
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // stop_kind: 1 = abort, 2 = RST_N, applied in the first GLITCH cycle of attempt stop_attempt.
  task automatic runSweep(input int hit_attempt, input int hit_cycle, input logic [7:0] hit_code,
                          input int stop_attempt, input int stop_kind, input int stall);
    logic [7:0] last;
    bit hit;
    int w;
    last = 8'h00;
    for (int k = 0; k < plan.size(); k++) begin
      checkOutput("cur_delay", {16'd0, cur_delay}, plan[k].d);
      checkOutput("cur_len", {16'd0, cur_len}, plan[k].l);
      checkOutput("attempts", {8'd0, attempts}, k);
      for (int i = 0; i < RC; i++) applyStimulus("reset_phase", V_RESET, noisyCode());
      for (int i = 0; i < plan[k].d; i++) applyStimulus("delay_phase", V_DELAY, noisyCode());
      if (k + 1 == stop_attempt) begin
        if (stop_kind == 1) abort = 1'b1;
        else RST_N = 1'b0;
        applyStimulus("glitch_phase", V_GLITCH, noisyCode());
        abort = 1'b0;
        RST_N = 1'b1;
        applyStimulus("after_stop", V_IDLE, quietCode());
        checkOutput("kept_attempts", {8'd0, attempts}, (stop_kind == 1) ? k : 0);
        checkOutput("kept_delay", {16'd0, cur_delay}, (stop_kind == 1) ? plan[k].d : int'(DMIN));
        checkOutput("kept_len", {16'd0, cur_len}, (stop_kind == 1) ? plan[k].l : int'(LMIN));
        if (stop_kind == 2) begin
          checkOutput("reset_code", {24'd0, result_code}, 0);
          checkOutput("reset_found", {31'd0, found}, 0);
        end
        return;
      end
      for (int i = 0; i < plan[k].l; i++) applyStimulus("glitch_phase", V_GLITCH, noisyCode());
      hit = (k + 1 == hit_attempt);
      w = hit ? hit_cycle : int'(WIN);
      for (int i = 0; i < w; i++) begin
        last = (hit && i == w - 1) ? hit_code : quietCode();
        applyStimulus("watch_phase", V_WATCH, last);
      end
      checkOutput("result_code", {24'd0, result_code}, {24'd0, last});
      if (REPORT_EN) begin
        if (k == 0 && stall > 0) begin
          result_ready = 1'b0;
          for (int i = 0; i < stall; i++) begin
            applyStimulus("report_stall", V_REPORT, noisyCode());
            checkOutput("stall_code", {24'd0, result_code}, {24'd0, last});
          end
          result_ready = 1'b1;
        end
        applyStimulus("report", V_REPORT, noisyCode());
      end
      if (hit) begin
        checkOutput("hold_found", {31'd0, found}, 1);
        checkOutput("hold_attempts", {8'd0, attempts}, k + 1);
        for (int i = 0; i < 12; i++) applyStimulus("hold", V_IDLE, noisyCode());
        checkOutput("hold_code", {24'd0, result_code}, {24'd0, hit_code});
        return;
      end
    end
    checkOutput("done_attempts", {8'd0, attempts}, plan.size());
    checkOutput("done_found", {31'd0, found}, 0);
    checkOutput("done_delay", {16'd0, cur_delay}, {16'd0, DMAX});
    checkOutput("done_len", {16'd0, cur_len}, {16'd0, LMAX});
    for (int i = 0; i < 6; i++) applyStimulus("done", V_IDLE, noisyCode());
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; abort = 1'b0; result_ready = 1'b1; dbg = 8'h00;
    for (int l = LMIN; l <= LMAX; l++)
      for (int d = DMIN; d <= DMAX; d++)
        plan.push_back('{d, l});

    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_attempts", {8'd0, attempts}, 0);
    checkOutput("rst_delay", {16'd0, cur_delay}, {16'd0, DMIN});
    checkOutput("rst_len", {16'd0, cur_len}, {16'd0, LMIN});
    checkOutput("rst_found", {31'd0, found}, 0);
    checkOutput("rst_code", {24'd0, result_code}, 0);
    applyStimulus("rst_outputs", V_IDLE, 8'h00);
    RST_N = 1'b1;
    applyStimulus("idle", V_IDLE, 8'h88);

    startSweep(); runSweep(0, 0, 8'h00, 0, 0, 0);
    startSweep(); runSweep(0, 0, 8'h00, 0, 0, 10);
    startSweep(); runSweep(2, 3, 8'h88, 0, 0, 0);
    startSweep(); runSweep($urandom_range(1, 4), $urandom_range(1, 8),
                           ($urandom_range(1) == 1) ? 8'h25 : 8'h88, 0, 0, 0);
    startSweep(); runSweep(0, 0, 8'h00, 2, 1, 0);

    start = 1'b1; abort = 1'b1;
    applyStimulus("start_abort", V_IDLE, 8'h00);
    start = 1'b0; abort = 1'b0;
    applyStimulus("start_abort_idle", V_IDLE, 8'h00);

    startSweep(); runSweep(0, 0, 8'h00, 3, 2, 0);
    startSweep(); runSweep(0, 0, 8'h00, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glitch_sweep_sched.md
GLITCH_SWEEP_SCHED -- requirements
Module: glitch_sweep_sched

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16'h0010: cycles the console reset is held low per attempt.
REQ-002 SHALL have parameter DELAY_MIN, default 16'h0001: first glitch delay, in cycles after reset release.
REQ-003 SHALL have parameter DELAY_MAX, default 16'h0300: last glitch delay before the delay wraps.
REQ-004 SHALL have parameter LEN_MIN, default 16'h0100: first glitch pulse length, in cycles.
REQ-005 SHALL have parameter LEN_MAX, default 16'h0180: last glitch pulse length before the sweep ends.
REQ-006 SHALL have parameter WIN_CYCLES, default 24'hF0000: watch window per attempt, in cycles.
REQ-007 SHALL have parameters SUCCESS_A, default 8'h88, and SUCCESS_B, default 8'h25: debug codes that mean success.
REQ-008 CLK  input  1  single clock for all logic.
REQ-009 RST_N  input  1  reset; synchronous, active-low.
REQ-010 start  input  1  one-cycle pulse; begins a fresh sweep.
REQ-011 abort  input  1  one-cycle pulse; stops the sweep.
REQ-012 dbg  input  8  debug-LED code, already synchronised to CLK.
REQ-013 reset_out_n  output  1  console reset, active-low.
REQ-014 glitch_out  output  1  glitch MOSFET gate, active-high.
REQ-015 busy  output  1  high in RESET, DELAY, GLITCH, WATCH and REPORT.
REQ-016 found  output  1  high when a success code has been latched.
REQ-017 cur_delay  output  16  delay used by the current or last attempt.
REQ-018 cur_len  output  16  pulse length used by the current or last attempt.
REQ-019 attempts  output  24  attempts completed; saturates at 24'hFFFFFF.
REQ-020 result_valid  output  1  per-attempt report valid.
REQ-021 result_code  output  8  dbg value captured at the end of WATCH.
REQ-022 result_ready  input  1  consumer accepts the report.

Function
REQ-023 SHALL implement the states IDLE, RESET, DELAY, GLITCH, WATCH, REPORT, HOLD and DONE; all outputs SHALL be registered.
REQ-024 start sampled in IDLE, HOLD or DONE SHALL load cur_delay=DELAY_MIN, cur_len=LEN_MIN and attempts=0, clear found, and enter RESET on the next cycle; start in any other state SHALL be ignored.
REQ-025 RESET SHALL drive reset_out_n=0 for exactly RESET_CYCLES cycles, then go to DELAY.
REQ-026 DELAY SHALL last exactly cur_delay cycles with reset_out_n=1, then go to GLITCH.
REQ-027 GLITCH SHALL hold glitch_out=1 for exactly cur_len cycles, then go to WATCH; glitch_out SHALL be 0 in every other state.
REQ-028 WATCH SHALL end early if dbg equals SUCCESS_A or SUCCESS_B, and otherwise after WIN_CYCLES cycles.
REQ-029 dbg SHALL be ignored in RESET, DELAY and GLITCH, because the pins float during reset.
REQ-030 At the end of WATCH the block SHALL capture result_code=dbg, increment attempts (saturating), and enter REPORT.
REQ-031 REPORT SHALL hold result_valid=1 with stable result_code until a cycle where result_valid and result_ready are both 1; result_valid SHALL drop the cycle after that.
REQ-032 After the handshake, a success capture SHALL enter HOLD with found=1, reset_out_n=1 and glitch_out=0, and HOLD SHALL stay until start or abort.
REQ-033 After the handshake, a non-success capture SHALL advance the parameters and re-enter RESET:
- if cur_delay<DELAY_MAX, cur_delay+1;
- otherwise cur_delay=DELAY_MIN and cur_len+1;
- if cur_delay=DELAY_MAX and cur_len=LEN_MAX, go to DONE instead, with parameters unchanged.
REQ-034 abort SHALL force IDLE on the next cycle from any state, with reset_out_n=1, glitch_out=0 and result_valid=0; cur_delay, cur_len, attempts and found SHALL be retained.
REQ-035 If start and abort are sampled in the same cycle, abort SHALL win.
REQ-036 Delay and length increments SHALL be 16-bit; DELAY_MIN<=DELAY_MAX and LEN_MIN<=LEN_MAX are the caller's obligation.
REQ-037 DELAY_MIN=0 SHALL give a zero-cycle DELAY, i.e. GLITCH starts on the first cycle after reset release.

Reset
REQ-038 RST_N=0 at a CLK edge SHALL set: state=IDLE, reset_out_n=1, glitch_out=0, busy=0, found=0, result_valid=0, result_code=0, attempts=0, cur_delay=DELAY_MIN, cur_len=LEN_MIN.
REQ-039 Reset SHALL take precedence over start, abort and result_ready, including in the middle of a glitch pulse or a report.

Configuration
REQ-040 With macro GLITCH_SWEEP_REPORT_EN defined, the REPORT state and the result handshake SHALL behave as in REQ-031.
REQ-041 With GLITCH_SWEEP_REPORT_EN undefined, REPORT SHALL be omitted, WATCH SHALL go straight to the advance/HOLD decision, result_valid SHALL be tied to 0, and result_ready SHALL be ignored; result_code SHALL still be captured.

Verification
Bench parameters: RESET_CYCLES=4, DELAY 2..3, LEN 1..2, WIN_CYCLES=8, result_ready tied 1.
REQ-042 No success code -> exactly 4 attempts, (delay,len) = (2,1),(3,1),(2,2),(3,2); then DONE with attempts=4 and busy=0.
REQ-043 Cycle check -> reset_out_n low for 4 cycles; glitch_out rises 2 cycles after reset release, high for 1 cycle.
REQ-044 dbg=8'h88 on the 3rd WATCH cycle of attempt 2 -> result_code=8'h88, found=1, HOLD, attempts=2, no further reset pulses.
REQ-045 result_ready held 0 for 10 cycles in REPORT -> result_valid and result_code stable for those 10 cycles; next RESET starts on the cycle after the handshake.
REQ-046 abort during GLITCH -> glitch_out=0 and IDLE the next cycle; a later start restarts at (2,1) with attempts=0.
REQ-047 dbg=8'h25 during RESET only -> ignored; the sweep continues.
